// File: rtl/mem_access_sb_if.sv
// Request and data-memory bus bundle for the memory-access stage.
interface mem_access_sb_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             req_valid;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_ready;
  logic [31:0]      rdata;
  logic             rdata_valid;
  logic             addr_err;
  logic [CNT_W-1:0] sb_count;
  logic             sb_empty;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;

  // Stage view: accepts pipeline accesses and drives the memory port
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rdata, rdata_valid, addr_err, sb_count, sb_empty,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // Environment view: pipeline plus data memory
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rdata, rdata_valid, addr_err, sb_count, sb_empty,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_sb.sv
// MIPS memory-access stage: sub-word loads/stores, posted store buffer,
// single-outstanding req/ack data-memory port.
module mem_access_sb #(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned CNT_W    = 3
) (
  input logic            clk,
  input logic            reset,
  mem_access_sb_if.slave bus
);

  localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_STORE = 2'd1;
  localparam logic [1:0] M_LOAD  = 2'd2;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

  // Store buffer
  sb_entry_t           sb_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                sb_empty_q;

  // Port FSM and registered outputs
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        mem_req_q,   mem_req_nxt;
  logic        mem_we_q,    mem_we_nxt;
  logic [31:0] mem_addr_q,  mem_addr_nxt;
  logic [3:0]  mem_be_q,    mem_be_nxt;
  logic [31:0] mem_wdata_q, mem_wdata_nxt;
  logic [31:0] rdata_q,     rdata_nxt;
  logic        rdata_valid_q, rdata_valid_nxt;
  logic        addr_err_q;

  // Pending load
  logic        ld_pend;
  logic        ld_pend_nxt;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;

  // Combinational helpers
  logic                ready_c;
  logic                sb_full_c;
  logic                accept_c;
  logic                misalign_c;
  logic                enq_c;
  logic                ld_acc_c;
  logic                pop_c;
  logic                sb_any_c;
  logic                hazard_c;
  logic [SB_DEPTH-1:0] match_c;
  logic [29:0]         ld_waddr_c;
  sb_entry_t           in_entry_c;
  sb_entry_t           sb_head_c;
  sb_entry_t           st_src_c;
  logic [7:0]          lane_b_c;
  logic [15:0]         lane_h_c;
  logic [31:0]         ld_ext_c;

  // Accept decode; credit comes only from the registered occupancy
  assign sb_full_c = (cnt_q == CNT_W'(SB_DEPTH));
  assign ready_c   = !ld_pend && !(bus.req_write && sb_full_c);
  assign accept_c  = bus.req_valid && ready_c;
  assign enq_c     = accept_c && bus.req_write && !misalign_c;
  assign ld_acc_c  = accept_c && !bus.req_write && !misalign_c;

  // Alignment check; size 3 behaves as word
  always_comb begin
    misalign_c = 1'b0;
    case (bus.req_size)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = bus.req_addr[0];
      default: misalign_c = |bus.req_addr[1:0];
    endcase
  end

  // Lane-align incoming store data and build its byte enables
  always_comb begin
    in_entry_c.waddr = bus.req_addr[31:2];
    in_entry_c.be    = 4'b1111;
    in_entry_c.data  = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        in_entry_c.be   = 4'b0001 << bus.req_addr[1:0];
        in_entry_c.data = {24'h0, bus.req_wdata[7:0]} << {bus.req_addr[1:0], 3'b000};
      end
      2'd1: begin
        in_entry_c.be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        in_entry_c.data = bus.req_addr[1] ? {bus.req_wdata[15:0], 16'h0}
                                          : {16'h0, bus.req_wdata[15:0]};
      end
      default: begin
        in_entry_c.be   = 4'b1111;
        in_entry_c.data = bus.req_wdata;
      end
    endcase
  end

  // Word-address match of the candidate load against every live buffer entry
  assign ld_waddr_c = ld_pend ? ld_addr[31:2] : bus.req_addr[31:2];
  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_match
    assign match_c[g] = sb_vld[g] && (sb_mem[g].waddr == ld_waddr_c);
  end
  assign hazard_c  = |match_c;
  assign sb_any_c  = |sb_vld;
  assign sb_head_c = sb_mem[rd_ptr];
  assign st_src_c  = sb_any_c ? sb_head_c : in_entry_c;

  // Extract and extend the returning load word
  always_comb begin
    lane_b_c = 8'(bus.mem_rdata >> {ld_addr[1:0], 3'b000});
    lane_h_c = ld_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (ld_size)
      2'd0:    ld_ext_c = {{24{ld_signed & lane_b_c[7]}}, lane_b_c};
      2'd1:    ld_ext_c = {{16{ld_signed & lane_h_c[15]}}, lane_h_c};
      default: ld_ext_c = bus.mem_rdata;
    endcase
  end

  // Port FSM next state and registered-output next values
  always_comb begin
    state_nxt       = state;
    mem_req_nxt     = mem_req_q;
    mem_we_nxt      = mem_we_q;
    mem_addr_nxt    = mem_addr_q;
    mem_be_nxt      = mem_be_q;
    mem_wdata_nxt   = mem_wdata_q;
    rdata_nxt       = rdata_q;
    rdata_valid_nxt = 1'b0;
    ld_pend_nxt     = ld_pend | ld_acc_c;
    pop_c           = 1'b0;
    case (state)
      M_IDLE: begin
        if ((ld_pend || ld_acc_c) && !hazard_c) begin
          state_nxt    = M_LOAD;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = {ld_waddr_c, 2'b00};
          mem_be_nxt   = 4'b1111;
        end else if (sb_any_c || enq_c) begin
          state_nxt     = M_STORE;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = {st_src_c.waddr, 2'b00};
          mem_be_nxt    = st_src_c.be;
          mem_wdata_nxt = st_src_c.data;
        end
      end
      M_STORE: begin
        if (bus.mem_ack) begin
          state_nxt   = M_IDLE;
          mem_req_nxt = 1'b0;
          pop_c       = 1'b1;
        end
      end
      M_LOAD: begin
        if (bus.mem_ack) begin
          state_nxt       = M_IDLE;
          mem_req_nxt     = 1'b0;
          rdata_nxt       = ld_ext_c;
          rdata_valid_nxt = 1'b1;
          ld_pend_nxt     = 1'b0;
        end
      end
      default: begin
        state_nxt   = M_IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign cnt_nxt = cnt_q + CNT_W'(enq_c) - CNT_W'(pop_c);

  // FSM state and memory-port/result output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= M_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_req_q     <= mem_req_nxt;
      mem_we_q      <= mem_we_nxt;
      mem_addr_q    <= mem_addr_nxt;
      mem_be_q      <= mem_be_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
      rdata_q       <= rdata_nxt;
      rdata_valid_q <= rdata_valid_nxt;
      addr_err_q    <= accept_c && misalign_c;
    end
  end

  // Latch the accepted load so the pipeline inputs may change underneath it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_pend   <= 1'b0;
      ld_addr   <= '0;
      ld_size   <= '0;
      ld_signed <= 1'b0;
    end else begin
      ld_pend <= ld_pend_nxt;
      if (ld_acc_c) begin
        ld_addr   <= bus.req_addr;
        ld_size   <= bus.req_size;
        ld_signed <= bus.req_signed;
      end
    end
  end

  // Store-buffer control: pointers, per-entry valid bits, occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sb_vld     <= '0;
      cnt_q      <= '0;
      sb_empty_q <= 1'b1;
    end else begin
      if (pop_c) begin
        sb_vld[rd_ptr] <= 1'b0;
        rd_ptr <= (rd_ptr == PTR_W'(SB_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (enq_c) begin
        sb_vld[wr_ptr] <= 1'b1;
        wr_ptr <= (wr_ptr == PTR_W'(SB_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      cnt_q      <= cnt_nxt;
      sb_empty_q <= (cnt_nxt == '0);
    end
  end

  // Store-buffer payload storage; liveness is tracked by sb_vld
  always_ff @(posedge clk) begin
    if (enq_c) begin
      sb_mem[wr_ptr] <= in_entry_c;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.sb_count    = cnt_q;
  assign bus.sb_empty    = sb_empty_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sb.sv
// Directed bench for mem_access_sb with a hand-driven memory port.
module tb_mem_access_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_sb_if #(.CNT_W(3)) bus ();

  mem_access_sb #(.SB_DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_req();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.sb_empty !== 1'b1) begin n_err++; $display("FAIL rst_sb_empty got %b want 1", bus.sb_empty); end
    n_cmp++; if (bus.sb_count !== 3'd0) begin n_err++; $display("FAIL rst_sb_count got %0d want 0", bus.sb_count); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_err++; $display("FAIL rst_rdata_valid got %b want 0", bus.rdata_valid); end
    n_cmp++; if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL rst_addr_err got %b want 0", bus.addr_err); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
    n_cmp++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'h0) begin n_err++; $display("FAIL rst_mem_bus got we=%b be=%b a=%h d=%h want all 0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req got %b want 0", bus.mem_req); end
  endtask

  task automatic test_byte_store();
    drive_req(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h0000_00AB);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready got %b want 1", bus.req_ready); end
    tick();
    idle_req();
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL sb_mem_req got %b want 1", bus.mem_req); end
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL sb_mem_we got %b want 1", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL sb_mem_addr got %h want 00001000", bus.mem_addr); end
    n_cmp++; if (bus.mem_be !== 4'b0010) begin n_err++; $display("FAIL sb_mem_be got %b want 0010", bus.mem_be); end
    n_cmp++; if (bus.mem_wdata !== 32'h0000_AB00) begin n_err++; $display("FAIL sb_mem_wdata got %h want 0000ab00", bus.mem_wdata); end
    n_cmp++; if (bus.sb_count !== 3'd1) begin n_err++; $display("FAIL sb_count1 got %0d want 1", bus.sb_count); end
    n_cmp++; if (bus.sb_empty !== 1'b0) begin n_err++; $display("FAIL sb_empty0 got %b want 0", bus.sb_empty); end
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_1000}) begin n_err++; $display("FAIL sb_hold got req=%b a=%h want 1 00001000", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL sb_bubble got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.sb_count !== 3'd0) begin n_err++; $display("FAIL sb_count0 got %0d want 0", bus.sb_count); end
    n_cmp++; if (bus.sb_empty !== 1'b1) begin n_err++; $display("FAIL sb_empty1 got %b want 1", bus.sb_empty); end
    tick();
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2};
    logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [5] = '{32'h2002, 32'h2002, 32'h2003, 32'h2001, 32'h2000};
    logic [31:0] ex [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0012, 32'h8001_1234};
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
      tick();
      idle_req();
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL ld%0d_stall got %b want 0", i, bus.req_ready); end
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_2000}) begin n_err++; $display("FAIL ld%0d_issue got req=%b we=%b be=%b a=%h want 1 0 1111 00002000", i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); end
      bus.mem_rdata = 32'h8001_1234;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_err++; $display("FAIL ld%0d_valid got %b want 1", i, bus.rdata_valid); end
      n_cmp++; if (bus.rdata !== ex[i]) begin n_err++; $display("FAIL ld%0d_rdata got %h want %h", i, bus.rdata, ex[i]); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL ld%0d_ready got %b want 1", i, bus.req_ready); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ld%0d_bubble got %b want 0", i, bus.mem_req); end
      tick();
      n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_err++; $display("FAIL ld%0d_pulse got %b want 0", i, bus.rdata_valid); end
    end
  endtask

  task automatic test_buffer_full();
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 2'd2, 1'b0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
      tick();
    end
    drive_req(1'b1, 2'd2, 1'b0, 32'h310, 32'h1004);
    n_cmp++; if (bus.sb_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", bus.sb_count); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", bus.req_ready); end
    n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL full_head got req=%b a=%h want 1 00000300", bus.mem_req, bus.mem_addr); end
    tick();
    n_cmp++; if ({bus.sb_count, bus.req_ready} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL full_hold got cnt=%0d rdy=%b want 4 0", bus.sb_count, bus.req_ready); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++; if (bus.sb_count !== 3'd3) begin n_err++; $display("FAIL full_pop got %0d want 3", bus.sb_count); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL full_credit got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL full_bubble got %b want 0", bus.mem_req); end
    tick();
    idle_req();
    n_cmp++; if (bus.sb_count !== 3'd4) begin n_err++; $display("FAIL full_reaccept got %0d want 4", bus.sb_count); end
    for (int j = 1; j < 5; j++) begin
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h300 + 32'(4 * j), 32'h1000 + 32'(j)}) begin n_err++; $display("FAIL drain%0d got req=%b we=%b a=%h d=%h want 1 1 %h %h", j, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, 32'h300 + 32'(4 * j), 32'h1000 + 32'(j)); end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
    end
    n_cmp++; if ({bus.sb_count, bus.sb_empty, bus.mem_req} !== {3'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL drain_done got cnt=%0d empty=%b req=%b want 0 1 0", bus.sb_count, bus.sb_empty, bus.mem_req); end
  endtask

  task automatic test_load_hazard();
    drive_req(1'b1, 2'd2, 1'b0, 32'h180, 32'h0000_000A);
    tick();
    drive_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344);
    tick();
    drive_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    tick();
    idle_req();
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL hz_stall got %b want 0", bus.req_ready); end
    n_cmp++; if ({bus.mem_we, bus.mem_addr, bus.sb_count} !== {1'b1, 32'h180, 3'd2}) begin n_err++; $display("FAIL hz_first got we=%b a=%h cnt=%0d want 1 00000180 2", bus.mem_we, bus.mem_addr, bus.sb_count); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'h1122_3344}) begin n_err++; $display("FAIL hz_store_first got req=%b we=%b a=%h d=%h want 1 1 00000100 11223344", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++; if ({bus.mem_req, bus.sb_count} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL hz_drained got req=%b cnt=%0d want 0 0", bus.mem_req, bus.sb_count); end
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin n_err++; $display("FAIL hz_load_issue got req=%b we=%b a=%h want 1 0 00000100", bus.mem_req, bus.mem_we, bus.mem_addr); end
    bus.mem_rdata = 32'h1122_3344;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++; if ({bus.rdata_valid, bus.rdata} !== {1'b1, 32'h1122_3344}) begin n_err++; $display("FAIL hz_rdata got v=%b d=%h want 1 11223344", bus.rdata_valid, bus.rdata); end
    tick();
  endtask

  task automatic test_load_bypass();
    drive_req(1'b1, 2'd2, 1'b0, 32'h180, 32'h0000_000B);
    tick();
    drive_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h5566_7788);
    tick();
    drive_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    tick();
    idle_req();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h200}) begin n_err++; $display("FAIL bp_load_first got req=%b we=%b a=%h want 1 0 00000200", bus.mem_req, bus.mem_we, bus.mem_addr); end
    n_cmp++; if (bus.sb_count !== 3'd1) begin n_err++; $display("FAIL bp_count got %0d want 1", bus.sb_count); end
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++; if ({bus.rdata_valid, bus.rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_err++; $display("FAIL bp_rdata got v=%b d=%h want 1 cafef00d", bus.rdata_valid, bus.rdata); end
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'h5566_7788}) begin n_err++; $display("FAIL bp_store_after got req=%b we=%b a=%h d=%h want 1 1 00000100 55667788", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    drive_req(1'b0, 2'd2, 1'b0, 32'h3, 32'h0);
    tick();
    drive_req(1'b0, 2'd1, 1'b1, 32'h5, 32'h0);
    n_cmp++; if ({bus.addr_err, bus.mem_req, bus.rdata_valid, bus.req_ready} !== 4'b1001) begin n_err++; $display("FAIL mis_lw got err=%b req=%b v=%b rdy=%b want 1 0 0 1", bus.addr_err, bus.mem_req, bus.rdata_valid, bus.req_ready); end
    tick();
    drive_req(1'b1, 2'd1, 1'b0, 32'h7, 32'h1234);
    n_cmp++; if ({bus.addr_err, bus.mem_req, bus.rdata_valid} !== 3'b100) begin n_err++; $display("FAIL mis_lh got err=%b req=%b v=%b want 1 0 0", bus.addr_err, bus.mem_req, bus.rdata_valid); end
    tick();
    idle_req();
    n_cmp++; if ({bus.addr_err, bus.sb_count} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL mis_sh got err=%b cnt=%0d want 1 0", bus.addr_err, bus.sb_count); end
    tick();
    n_cmp++; if ({bus.addr_err, bus.mem_req, bus.rdata_valid} !== 3'b000) begin n_err++; $display("FAIL mis_after got err=%b req=%b v=%b want 0 0 0", bus.addr_err, bus.mem_req, bus.rdata_valid); end
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 2'd2, 1'b0, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    idle_req();
    n_cmp++; if ({bus.mem_req, bus.sb_count} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL rmo_setup got req=%b cnt=%0d want 1 3", bus.mem_req, bus.sb_count); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_req, bus.sb_count, bus.sb_empty, bus.req_ready} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL rmo_ctrl got req=%b cnt=%0d empty=%b rdy=%b want 0 0 1 1", bus.mem_req, bus.sb_count, bus.sb_empty, bus.req_ready); end
    n_cmp++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'h0) begin n_err++; $display("FAIL rmo_bus got we=%b be=%b a=%h d=%h want all 0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if ({bus.rdata, bus.rdata_valid, bus.addr_err} !== 34'h0) begin n_err++; $display("FAIL rmo_result got d=%h v=%b err=%b want 0 0 0", bus.rdata, bus.rdata_valid, bus.addr_err); end
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rmo_no_req%0d got %b want 0", k, bus.mem_req); end
    end
    n_cmp++; if ({bus.sb_count, bus.sb_empty} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL rmo_final got cnt=%0d empty=%b want 0 1", bus.sb_count, bus.sb_empty); end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_load_extend();
    test_buffer_full();
    test_load_hazard();
    test_load_bypass();
    test_misaligned();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
